// File: rtl/pkt_tx_serializer.sv
// Packet transmit serializer: buffers PKT_BYTES payload bytes, then shifts out
// preamble, sync, payload (MSB first) and an even-parity bit, one bit per bit_en.
module pkt_tx_serializer #(
  parameter int unsigned PKT_BYTES = 8,
  parameter logic [7:0]  PREAMBLE  = 8'hAA,
  parameter logic [7:0]  SYNC      = 8'hD3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       wr,
  input  logic       start,
  input  logic       bit_en,
  output logic       dout,
  output logic       busy,
  output logic       full,
  output logic [3:0] byte_cnt,
  output logic       done,
  output logic       wr_drop
);

  localparam int unsigned IDX_W    = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam logic [3:0]  FULL_CNT = 4'(PKT_BYTES);
  localparam logic [3:0]  LAST_IDX = 4'(PKT_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_SYN  = 3'd2,
    S_PAY  = 3'd3,
    S_PAR  = 3'd4,
    S_END  = 3'd5
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] shift_reg, shift_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [3:0] pay_idx, pay_idx_nxt;
  logic       par_acc, par_nxt;
  logic       dout_nxt, busy_nxt, full_nxt, done_nxt, wr_drop_nxt;
  logic [3:0] byte_cnt_nxt;
  logic       buf_we;
  logic       accept_wr;

  logic [7:0] mem [PKT_BYTES];

  // Payload buffer; contents need no reset since byte_cnt gates every read.
  always_ff @(posedge clk) begin
    if (buf_we) mem[byte_cnt[IDX_W-1:0]] <= din;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      pay_idx   <= '0;
      par_acc   <= 1'b0;
      dout      <= 1'b0;
      busy      <= 1'b0;
      full      <= 1'b0;
      byte_cnt  <= '0;
      done      <= 1'b0;
      wr_drop   <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      pay_idx   <= pay_idx_nxt;
      par_acc   <= par_nxt;
      dout      <= dout_nxt;
      busy      <= busy_nxt;
      full      <= full_nxt;
      byte_cnt  <= byte_cnt_nxt;
      done      <= done_nxt;
      wr_drop   <= wr_drop_nxt;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_reg;
    bit_cnt_nxt  = bit_cnt;
    pay_idx_nxt  = pay_idx;
    par_nxt      = par_acc;
    busy_nxt     = busy;
    byte_cnt_nxt = byte_cnt;
    done_nxt     = 1'b0;
    buf_we       = 1'b0;
    dout_nxt     = 1'b0;

    // Writes are only taken while idle with room left; start sees the old full.
    accept_wr   = wr && (state == S_IDLE) && !full;
    wr_drop_nxt = wr && !accept_wr;

    case (state)
      S_IDLE: begin
        if (start && full) begin
          state_nxt   = S_PRE;
          shift_nxt   = PREAMBLE;
          bit_cnt_nxt = '0;
          par_nxt     = 1'b0;
          busy_nxt    = 1'b1;
        end else if (accept_wr) begin
          buf_we       = 1'b1;
          byte_cnt_nxt = byte_cnt + 4'd1;
        end
      end
      S_PRE, S_SYN, S_PAY: begin
        if (bit_en) begin
          shift_nxt   = {shift_reg[6:0], 1'b0};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (state == S_PAY) par_nxt = par_acc ^ shift_reg[7];
          if (bit_cnt == 3'd7) begin
            if (state == S_PRE) begin
              shift_nxt = SYNC;
              state_nxt = S_SYN;
            end else if (state == S_SYN) begin
              shift_nxt   = mem[0];
              pay_idx_nxt = '0;
              state_nxt   = S_PAY;
            end else if (pay_idx == LAST_IDX) begin
              state_nxt = S_PAR;
            end else begin
              pay_idx_nxt = pay_idx + 4'd1;
              shift_nxt   = mem[pay_idx_nxt[IDX_W-1:0]];
            end
          end
        end
      end
      S_PAR: begin
        if (bit_en) state_nxt = S_END;
      end
      S_END: begin
        state_nxt    = S_IDLE;
        done_nxt     = 1'b1;
        busy_nxt     = 1'b0;
        byte_cnt_nxt = '0;
      end
      default: state_nxt = S_IDLE;
    endcase

    full_nxt = (byte_cnt_nxt == FULL_CNT);

    // Line value for the cycle after this edge, derived from the next state.
    case (state_nxt)
      S_PRE, S_SYN, S_PAY: dout_nxt = shift_nxt[7];
      S_PAR:               dout_nxt = par_nxt;
      default:             dout_nxt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_pkt_tx_serializer.sv
// Self-checking bench for pkt_tx_serializer: a frame-level queue model predicts
// every output each cycle; literal frame images pin the model.
module tb_pkt_tx_serializer;

  localparam int unsigned N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       wr, start, bit_en;
  logic       dout, busy, full, done, wr_drop;
  logic [3:0] byte_cnt;

  int checks = 0;
  int errors = 0;

  pkt_tx_serializer #(.PKT_BYTES(N), .PREAMBLE(8'hAA), .SYNC(8'hD3)) dut (
    .clk(clk), .rst(rst), .din(din), .wr(wr), .start(start), .bit_en(bit_en),
    .dout(dout), .busy(busy), .full(full), .byte_cnt(byte_cnt),
    .done(done), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_mode;      // 0 idle, 1 sending, 2 trailing idle bit
  int         m_cnt;
  logic [7:0] m_buf [N];
  bit         m_q [$];     // line bits still to send, head is on the line now
  bit         m_dout, m_done, m_drop;
  bit         line [$];    // DUT line bits sampled at each bit_en of the frame
  bit         last_line [$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_dout = 0; m_done = 0; m_drop = 0;
      m_q.delete();
      line.delete();
    end else begin
      m_done = (m_mode == 2);
      m_drop = wr && (m_mode != 0 || m_cnt == N);
      case (m_mode)
        0: begin
          if (start && m_cnt == N) begin
            logic [7:0] bytes [N+2];
            bit par;
            bytes[0] = 8'hAA;
            bytes[1] = 8'hD3;
            for (int i = 0; i < N; i++) bytes[i+2] = m_buf[i];
            par = 0;
            m_q.delete();
            for (int i = 0; i < N + 2; i++)
              for (int b = 7; b >= 0; b--) begin
                m_q.push_back(bytes[i][b]);
                if (i >= 2) par ^= bytes[i][b];
              end
            m_q.push_back(par);
            line.delete();
            m_mode = 1;
            m_dout = m_q[0];
          end else if (wr && m_cnt < N) begin
            m_buf[m_cnt] = din;
            m_cnt++;
          end
        end
        1: begin
          if (bit_en) begin
            line.push_back(dout);
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
              m_mode = 2;
              m_dout = 0;
              last_line = line;
            end else begin
              m_dout = m_q[0];
            end
          end
        end
        default: begin
          m_mode = 0;
          m_cnt  = 0;
        end
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("dout",     128'(dout),     128'(m_dout));
    chk("busy",     128'(busy),     128'(m_mode != 0));
    chk("full",     128'(full),     128'(m_cnt == N));
    chk("byte_cnt", 128'(byte_cnt), 128'(m_cnt));
    chk("done",     128'(done),     128'(m_done));
    chk("wr_drop",  128'(wr_drop),  128'(m_drop));
  end

  // ---------------- stimulus ----------------
  int be_mode = 0;  // 0 off, 1 every 4 clk, 2 always, 3 random
  int be_phase = 0;

  always @(posedge clk) begin
    #2;
    case (be_mode)
      1:       begin bit_en = (be_phase % 4 == 0); be_phase++; end
      2:       bit_en = 1'b1;
      3:       bit_en = ($urandom_range(0, 2) == 0);
      default: bit_en = 1'b0;
    endcase
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr = 1'b1; din = d;
    cyc();
    wr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    chk("done_seen", 128'(done), 128'(1));
    cyc();
  endtask

  function automatic logic [127:0] line_vec();
    logic [127:0] v = '0;
    foreach (last_line[i]) v = {v[126:0], last_line[i]};
    return v;
  endfunction

  logic [127:0] exp_v;

  initial begin
    rst = 1'b1; din = '0; wr = 1'b0; start = 1'b0; bit_en = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_cnt",  128'(byte_cnt), 128'(0));

    // Nominal frame, bit_en every 4 clocks.
    for (int i = 0; i < 8; i++) write_byte(8'(1 << i));
    write_byte(8'h99);  // ninth write while full
    chk("drop_full", 128'(wr_drop), 128'(1));
    chk("cnt_full",  128'(byte_cnt), 128'(8));
    be_phase = 0; be_mode = 1;
    pulse_start();
    wait_done(2000);
    exp_v = 128'({8'hAA, 8'hD3, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 1'b0});
    chk("nom_len",   128'(last_line.size()), 128'(81));
    chk("nom_frame", line_vec(), exp_v);
    chk("nom_cnt",   128'(byte_cnt), 128'(0));

    // Odd payload ones -> parity bit 1.
    be_mode = 0;
    write_byte(8'hFF);
    for (int i = 0; i < 6; i++) write_byte(8'h00);
    write_byte(8'h01);
    be_mode = 3;
    pulse_start();
    wait_done(5000);
    exp_v = 128'({8'hAA, 8'hD3, 8'hFF, 48'h0, 8'h01, 1'b1});
    chk("par_frame", line_vec(), exp_v);

    // Start before full is ignored; writes during busy are dropped.
    be_mode = 0;
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    pulse_start();
    cyc();
    chk("early_busy", 128'(busy), 128'(0));
    write_byte(8'h44); write_byte(8'h55); write_byte(8'h66);
    write_byte(8'h77); write_byte(8'h88);
    be_mode = 1;
    pulse_start();
    cyc();
    write_byte(8'h5A);
    chk("drop_busy", 128'(wr_drop), 128'(1));
    wait_done(2000);
    exp_v = 128'({8'hAA, 8'hD3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 1'b0});
    chk("busy_frame", line_vec(), exp_v);

    // Back-to-back frames with bit_en held high.
    be_mode = 2;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) write_byte(8'($urandom));
      pulse_start();
      wait_done(500);
      chk("b2b_len", 128'(last_line.size()), 128'(81));
    end

    // Reset in the middle of the payload.
    be_mode = 0;
    for (int i = 0; i < 8; i++) write_byte(8'hFF);
    be_mode = 1;
    pulse_start();
    begin
      int n = 0;
      while (line.size() < 30 && n < 1000) begin cyc(); n++; end
    end
    chk("reach_pay", 128'(busy), 128'(1));
    #1 rst = 1'b1;
    #1;
    chk("rst_dout_now", 128'(dout), 128'(0));
    chk("rst_busy_now", 128'(busy), 128'(0));
    chk("rst_cnt_now",  128'(byte_cnt), 128'(0));
    cyc(); cyc();
    rst = 1'b0;
    repeat (200) cyc();

    // Random traffic.
    be_mode = 3;
    for (int k = 0; k < 4000; k++) begin
      wr    = ($urandom_range(0, 2) == 0);
      din   = 8'($urandom);
      start = ($urandom_range(0, 7) == 0);
      cyc();
    end
    wr = 1'b0; start = 1'b0;
    repeat (20) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
